// File: rtl/host_arb2_if.sv
// Per-master command channel between one requester and host_arb2.
// Latency: none, pure signal bundle.
// Backpressure: requester holds cmd_vld and fields until cmd_rdy.
interface host_arb2_if;
  logic        cmd_vld;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic        rw;
  logic        cmd_rdy;
  logic [31:0] data_r;
  logic        rd_vld;
  logic        rd_err;

  // requester side: issues commands, receives read responses
  modport master (
    output cmd_vld, addr, data_w, rw,
    input  cmd_rdy, data_r, rd_vld, rd_err
  );

  // arbiter side: accepts commands, returns read responses
  modport slave (
    input  cmd_vld, addr, data_w, rw,
    output cmd_rdy, data_r, rd_vld, rd_err
  );
endinterface

// File: rtl/host_arb2.sv
// host_arb2: round-robin arbiter/sequencer letting two masters share one host command bus.
// Latency: accept -> s_cmd_vld next cycle; read response registered one cycle after s_rd_vld or timeout.
// Backpressure: only the IDLE winner sees cmd_rdy; one command in flight, losers keep waiting.
// Optional statistics ports are compiled in with HOST_ARB2_STATS_EN.
module host_arb2 #(
  parameter int unsigned RD_TIMEOUT   = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        reset,
  host_arb2_if.slave  m0,
  host_arb2_if.slave  m1,
  output logic        s_cmd_vld,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_w,
  output logic        s_rw,
  input  logic [31:0] s_data_r,
  input  logic        s_rd_vld,
  output logic        stray_rd
`ifdef HOST_ARB2_STATS_EN
  ,
  output logic [15:0] m0_grants,
  output logic [15:0] m1_grants,
  output logic [7:0]  rd_timeouts
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  // last counter value still inside the read window
  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        prio_q;      // 0: m0 wins a tie, 1: m1 wins a tie
  logic        own_q;       // master that issued the command in flight
  logic [31:0] addr_q;
  logic [31:0] data_w_q;
  logic        rw_q;
  logic [7:0]  cnt_q;
  logic        stray_q;

  logic        winner;
  logic        accept;
  logic        rsp_ok;
  logic        rsp_to;
  logic        rsp_fire;
  logic [31:0] rsp_dat;

  logic        m0_rd_vld_q, m0_rd_err_q;
  logic [31:0] m0_data_r_q;
  logic        m1_rd_vld_q, m1_rd_err_q;
  logic [31:0] m1_data_r_q;

  // next-state, arbitration and response-event decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rsp_ok  = 1'b0;
    rsp_to  = 1'b0;
    winner  = 1'b0;
    if (m0.cmd_vld && m1.cmd_vld) begin
      winner = prio_q;
    end else begin
      winner = m1.cmd_vld;
    end
    case (state_q)
      IDLE: begin
        if (m0.cmd_vld || m1.cmd_vld) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = rw_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        // a slave response in the final window cycle beats the timeout
        if (s_rd_vld) begin
          rsp_ok  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          rsp_to  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_fire = rsp_ok | rsp_to;
  assign rsp_dat  = rsp_ok ? s_data_r : TIMEOUT_DATA;

  assign m0.cmd_rdy = accept & ~winner;
  assign m1.cmd_rdy = accept & winner;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // capture the accepted command and hand priority to the other master
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q   <= 1'b0;
      own_q    <= 1'b0;
      addr_q   <= '0;
      data_w_q <= '0;
      rw_q     <= 1'b0;
    end else if (accept) begin
      prio_q   <= ~winner;
      own_q    <= winner;
      addr_q   <= winner ? m1.addr   : m0.addr;
      data_w_q <= winner ? m1.data_w : m0.data_w;
      rw_q     <= winner ? m1.rw     : m0.rw;
    end
  end

  // read-wait counter: cleared while issuing, counts every WAIT_RD cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_RD) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // registered response to the owning master; data holds between responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rd_vld_q <= 1'b0;
      m0_rd_err_q <= 1'b0;
      m0_data_r_q <= '0;
      m1_rd_vld_q <= 1'b0;
      m1_rd_err_q <= 1'b0;
      m1_data_r_q <= '0;
    end else begin
      m0_rd_vld_q <= rsp_fire & ~own_q;
      m0_rd_err_q <= rsp_fire & ~own_q & rsp_to;
      m1_rd_vld_q <= rsp_fire & own_q;
      m1_rd_err_q <= rsp_fire & own_q & rsp_to;
      if (rsp_fire && !own_q) begin
        m0_data_r_q <= rsp_dat;
      end
      if (rsp_fire && own_q) begin
        m1_data_r_q <= rsp_dat;
      end
    end
  end

  // sticky flag for slave read data arriving when no read is outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stray_q <= 1'b0;
    end else if (s_rd_vld && (state_q != WAIT_RD)) begin
      stray_q <= 1'b1;
    end
  end

`ifdef HOST_ARB2_STATS_EN
  // saturating grant and timeout counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_grants   <= '0;
      m1_grants   <= '0;
      rd_timeouts <= '0;
    end else begin
      if (accept && !winner && (m0_grants != 16'hffff)) begin
        m0_grants <= m0_grants + 16'd1;
      end
      if (accept && winner && (m1_grants != 16'hffff)) begin
        m1_grants <= m1_grants + 16'd1;
      end
      if (rsp_to && (rd_timeouts != 8'hff)) begin
        rd_timeouts <= rd_timeouts + 8'd1;
      end
    end
  end
`endif

  // downstream bus: fields hold the last issued command, strobe only in ISSUE
  assign s_cmd_vld = (state_q == ISSUE);
  assign s_addr    = addr_q;
  assign s_data_w  = data_w_q;
  assign s_rw      = rw_q;
  assign stray_rd  = stray_q;

  assign m0.rd_vld = m0_rd_vld_q;
  assign m0.rd_err = m0_rd_err_q;
  assign m0.data_r = m0_data_r_q;
  assign m1.rd_vld = m1_rd_vld_q;
  assign m1.rd_err = m1_rd_err_q;
  assign m1.data_r = m1_data_r_q;

endmodule

// File: tb/tb_host_arb2.sv
// Bench for host_arb2: directed scenarios plus random two-master traffic.
// Expected behaviour comes from a transaction-level model (grant rule, fixed latencies, timeout window).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_host_arb2;

  localparam int          T       = 16;
  localparam logic [31:0] TO_DATA = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_cmd_vld;
  logic [31:0] s_addr;
  logic [31:0] s_data_w;
  logic        s_rw;
  logic [31:0] s_data_r;
  logic        s_rd_vld;
  logic        stray_rd;
`ifdef HOST_ARB2_STATS_EN
  logic [15:0] m0_grants;
  logic [15:0] m1_grants;
  logic [7:0]  rd_timeouts;
`endif

  host_arb2_if m0_if ();
  host_arb2_if m1_if ();

  host_arb2 #(.RD_TIMEOUT(T), .TIMEOUT_DATA(TO_DATA)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_if),
    .m1         (m1_if),
    .s_cmd_vld  (s_cmd_vld),
    .s_addr     (s_addr),
    .s_data_w   (s_data_w),
    .s_rw       (s_rw),
    .s_data_r   (s_data_r),
    .s_rd_vld   (s_rd_vld),
    .stray_rd   (stray_rd)
`ifdef HOST_ARB2_STATS_EN
    ,
    .m0_grants  (m0_grants),
    .m1_grants  (m1_grants),
    .rd_timeouts(rd_timeouts)
`endif
  );

  always #5 clk = ~clk;

  // one command as a master sees it; k is the slave reply delay after s_cmd_vld (outside 1..T: no reply)
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
  } cmd_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t cur[2];
  bit   cur_vld[2];

  // reference model state
  int          free_at, issue_at, resp_at, slv_at;
  bit          ptr, rd_act, rsp_own, rsp_err, stray_m, pulse_stray;
  logic [31:0] rsp_data, slv_data, exp_addr, exp_wd;
  logic        exp_rw;
  logic [31:0] exp_dr[2];
  int          gcnt[2];
  int          tocnt;

  // observations of the DUT
  int dlog[$];
  int obs_rsp[2];
  int last_acc[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int k);
    cmd_t c;
    c.rw = rw; c.addr = a; c.wdata = wd; c.rdata = rd; c.k = k;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
              int'($urandom_range(1, T + 3)));
  endfunction

  task automatic drive_masters();
    m0_if.cmd_vld = cur_vld[0];
    m0_if.addr    = cur[0].addr;
    m0_if.data_w  = cur[0].wdata;
    m0_if.rw      = cur[0].rw;
    m1_if.cmd_vld = cur_vld[1];
    m1_if.addr    = cur[1].addr;
    m1_if.data_w  = cur[1].wdata;
    m1_if.rw      = cur[1].rw;
  endtask

  task automatic model_reset();
    free_at = 0; issue_at = -1; resp_at = -1; slv_at = -1;
    ptr = 0; rd_act = 0; rsp_own = 0; rsp_err = 0; stray_m = 0; pulse_stray = 0;
    rsp_data = '0; slv_data = '0; exp_addr = '0; exp_wd = '0; exp_rw = 1'b0;
    exp_dr[0] = '0; exp_dr[1] = '0;
    gcnt[0] = 0; gcnt[1] = 0; tocnt = 0;
    obs_rsp[0] = -1; obs_rsp[1] = -1; last_acc[0] = -1; last_acc[1] = -1;
    cur_vld[0] = 0; cur_vld[1] = 0;
    cur[0] = mk(1'b0, '0, '0, '0, 0);
    cur[1] = mk(1'b0, '0, '0, '0, 0);
    q0.delete(); q1.delete(); dlog.delete();
  endtask

  // assert reset mid-cycle, outputs must clear immediately
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive_masters();
    s_rd_vld = 1'b0;
    #1;
    check("rst_m0", {m0_if.cmd_rdy, m0_if.rd_vld, m0_if.rd_err, m0_if.data_r}, '0);
    check("rst_m1", {m1_if.cmd_rdy, m1_if.rd_vld, m1_if.rd_err, m1_if.data_r}, '0);
    check("rst_s_cmd", {s_cmd_vld, s_rw, s_addr}, '0);
    check("rst_s_data_w", s_data_w, '0);
    check("rst_stray", stray_rd, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // one clock cycle: drive, compare against the model, advance the model
  task automatic step();
    bit rv, waiting, acc, w;
    @(negedge clk);
    if (!cur_vld[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); cur_vld[0] = 1; end
    if (!cur_vld[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); cur_vld[1] = 1; end
    drive_masters();
    rv          = (cyc == slv_at) || pulse_stray;
    s_rd_vld    = rv;
    s_data_r    = (cyc == slv_at) ? slv_data : $urandom();
    pulse_stray = 0;
    #1;
    waiting = rd_act && (cyc > issue_at) && (cyc < resp_at);
    acc     = (cyc >= free_at) && (cur_vld[0] || cur_vld[1]);
    w       = (cur_vld[0] && cur_vld[1]) ? ptr : cur_vld[1];
    if (cyc == resp_at) exp_dr[rsp_own] = rsp_data;

    check("m0_cmd_rdy", m0_if.cmd_rdy, acc && !w);
    check("m1_cmd_rdy", m1_if.cmd_rdy, acc && w);
    check("s_cmd_vld", s_cmd_vld, cyc == issue_at);
    check("s_addr", s_addr, exp_addr);
    check("s_data_w", s_data_w, exp_wd);
    check("s_rw", s_rw, exp_rw);
    check("m0_rd_vld", m0_if.rd_vld, (cyc == resp_at) && !rsp_own);
    check("m1_rd_vld", m1_if.rd_vld, (cyc == resp_at) && rsp_own);
    check("m0_data_r", m0_if.data_r, exp_dr[0]);
    check("m1_data_r", m1_if.data_r, exp_dr[1]);
    if (cyc == resp_at)
      check("rd_err", rsp_own ? m1_if.rd_err : m0_if.rd_err, rsp_err);
    check("stray_rd", stray_rd, stray_m);

    if (m0_if.rd_vld === 1'b1) obs_rsp[0] = cyc;
    if (m1_if.rd_vld === 1'b1) obs_rsp[1] = cyc;
    if (m0_if.cmd_rdy === 1'b1) begin dlog.push_back(0); last_acc[0] = cyc; end
    if (m1_if.cmd_rdy === 1'b1) begin dlog.push_back(1); last_acc[1] = cyc; end
    if (rv && !waiting) stray_m = 1;

    if (acc) begin
      ptr      = !w;
      gcnt[w]++;
      issue_at = cyc + 1;
      exp_addr = cur[w].addr;
      exp_wd   = cur[w].wdata;
      exp_rw   = cur[w].rw;
      rsp_own  = w;
      if (cur[w].rw) begin
        rd_act  = 0;
        resp_at = -1;
        slv_at  = -1;
        free_at = cyc + 2;
      end else begin
        rd_act = 1;
        if (cur[w].k >= 1 && cur[w].k <= T) begin
          slv_at   = cyc + 1 + cur[w].k;
          slv_data = cur[w].rdata;
          resp_at  = cyc + 2 + cur[w].k;
          rsp_data = cur[w].rdata;
          rsp_err  = 0;
        end else begin
          slv_at   = -1;
          resp_at  = cyc + 2 + T;
          rsp_data = TO_DATA;
          rsp_err  = 1;
          tocnt++;
        end
        free_at = resp_at;
      end
      cur_vld[w] = 0;
    end
    cyc++;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((cur_vld[0] || cur_vld[1] || q0.size() > 0 || q1.size() > 0 || cyc <= free_at)
           && n < bound) begin
      step();
      n++;
    end
    if (cur_vld[0] || cur_vld[1] || q0.size() > 0 || q1.size() > 0 || cyc <= free_at)
      check("drain_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_issue;
    reset = 1'b0;
    s_rd_vld = 1'b0;
    s_data_r = '0;
    model_reset();
    drive_masters();
    #2;
    do_reset();

    // single write from m0
    q0.push_back(mk(1'b1, 32'ha000_0010, 32'h1234_5678, '0, 0));
    step();
    check("t1_acc_m0", last_acc[0], cyc - 1);
    step();
    check("t1_s_cmd_vld", s_cmd_vld, 1);
    check("t1_s_addr", s_addr, 32'ha000_0010);
    check("t1_s_data_w", s_data_w, 32'h1234_5678);
    check("t1_s_rw", s_rw, 1);
    wait_idle(20);
    check("t1_no_rsp", {obs_rsp[0], obs_rsp[1]}, {-32'sd1, -32'sd1});

    // both masters requesting continuously from reset
    do_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(1'b1, $urandom(), $urandom(), '0, 0));
      q1.push_back(mk(1'b1, $urandom(), $urandom(), '0, 0));
    end
    wait_idle(40);
    check("t2_grants", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++)
      check("t2_order", dlog[i], i % 2);

    // m1 read answered three cycles after the strobe
    q1.push_back(mk(1'b0, 32'hb000_0004, '0, 32'hcafe_0001, 3));
    wait_idle(40);
    check("t3_latency", obs_rsp[1] - issue_at, 4);
    check("t3_data", m1_if.data_r, 32'hcafe_0001);
    check("t3_m0_quiet", obs_rsp[0], -1);

    // m0 read timing out while m1 waits behind it
    q0.push_back(mk(1'b0, 32'hc000_0008, '0, '0, 0));
    step();
    rd_issue = issue_at;
    step();
    q1.push_back(mk(1'b1, 32'hd000_0000, 32'h0bad_f00d, '0, 0));
    wait_idle(60);
    check("t4_latency", obs_rsp[0] - rd_issue, T + 1);
    check("t4_data", m0_if.data_r, TO_DATA);
    check("t4_m1_after", last_acc[1], obs_rsp[0]);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!cur_vld[0] && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rnd_cmd());
      if (!cur_vld[1] && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rnd_cmd());
      step();
    end
    wait_idle(100);

`ifdef HOST_ARB2_STATS_EN
    check("m0_grants", m0_grants, gcnt[0]);
    check("m1_grants", m1_grants, gcnt[1]);
    check("rd_timeouts", rd_timeouts, tocnt);
`endif

    // stray slave read while idle
    pulse_stray = 1;
    step();
    repeat (3) step();
    check("t5_stray", stray_rd, 1);

    // reset during a read wait, then a late slave response
    q0.push_back(mk(1'b0, 32'he000_0000, '0, '0, 0));
    repeat (6) step();
    do_reset();
    pulse_stray = 1;
    step();
    repeat (T + 4) step();
    check("t6_stray", stray_rd, 1);
    check("t6_no_rsp", {obs_rsp[0], obs_rsp[1]}, {-32'sd1, -32'sd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
